// File: rtl/me_pkg.sv
// Shared motion-estimation constants, FSM encodings and the SAD width helper.
// Also used by the PE array so both sides agree on lane counts and widths.
package me_pkg;

    localparam int NUM_PE_DEF   = 16;
    localparam int AD_W_DEF     = 8;
    localparam int BLK_ROWS_DEF = 16;
    localparam int NUM_CAND_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } me_state_t;

    // Full-block SAD width: an AD_W lane summed over lanes*rows terms cannot overflow.
    function automatic int sad_width(input int ad_w, input int lanes, input int rows);
        return ad_w + $clog2(lanes * rows);
    endfunction

endpackage

// File: rtl/sad_min_tracker_ad_adder_tree.sv
// Combinational reduction of NUM_PE absolute-difference lanes into one row sum.
// The pipeline register for this sum lives in sad_min_tracker.
module ad_adder_tree #(
    parameter  int NUM_PE = 16,
    parameter  int AD_W   = 8,
    localparam int SUM_W  = AD_W + $clog2(NUM_PE)
) (
    input  logic [NUM_PE*AD_W-1:0] ad,
    output logic [SUM_W-1:0]       sum
);

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            sum = sum + SUM_W'(ad[k*AD_W +: AD_W]);
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Accumulates per-row AD sums into candidate SADs and tracks the minimum over a search.
// Optional early termination on a low-enough SAD is enabled by ME_EARLY_TERM_EN.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting row beats
// ST_FLUSH | two cycles draining the adder/accumulator/compare pipeline
// ST_DONE  | best result held, waiting for the next start
module sad_min_tracker
    import me_pkg::*;
#(
    parameter  int NUM_PE   = NUM_PE_DEF,
    parameter  int AD_W     = AD_W_DEF,
    parameter  int BLK_ROWS = BLK_ROWS_DEF,
    parameter  int NUM_CAND = NUM_CAND_DEF,
    localparam int SAD_W    = sad_width(AD_W, NUM_PE, BLK_ROWS),
    localparam int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ad_valid,
    input  logic [NUM_PE*AD_W-1:0] ad_i,
`ifdef ME_EARLY_TERM_EN
    input  logic [SAD_W-1:0]       term_thresh,
`endif
    output logic                   busy,
    output logic                   sad_valid,
    output logic [SAD_W-1:0]       sad_o,
    output logic [IDX_W-1:0]       sad_idx,
    output logic                   best_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx
);

    localparam int TREE_W = AD_W + $clog2(NUM_PE);
    localparam int ROW_W  = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);

    me_state_t          state, state_nxt;
    logic               flush_cnt, flush_cnt_nxt;
    logic               best_valid_nxt;
    logic               start_ok, accept, last_beat, final_beat, early_hit;
    logic [ROW_W-1:0]   row_cnt;
    logic [IDX_W-1:0]   cand_cnt;
    logic [TREE_W-1:0]  tree_sum;
    logic [TREE_W-1:0]  s1_sum;
    logic               s1_valid, s1_last;
    logic [IDX_W-1:0]   s1_idx;
    logic [SAD_W-1:0]   acc, acc_sum;

    ad_adder_tree #(.NUM_PE(NUM_PE), .AD_W(AD_W)) u_tree (
        .ad  (ad_i),
        .sum (tree_sum)
    );

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign accept     = ad_valid && (state == ST_RUN);
    assign last_beat  = accept && (row_cnt == ROW_LAST);
    assign final_beat = last_beat && (cand_cnt == IDX_LAST);
    assign acc_sum    = acc + SAD_W'(s1_sum);
    assign busy       = (state == ST_RUN) || (state == ST_FLUSH);

    // Decided one cycle before sad_valid so FLUSH can still be one cycle long.
`ifdef ME_EARLY_TERM_EN
    assign early_hit = (state == ST_RUN) && s1_valid && s1_last && (acc_sum <= term_thresh);
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= 1'b0;
            best_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            best_valid <= best_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = 1'b0;
        best_valid_nxt = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (early_hit) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = 1'b1;
                end else if (final_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_cnt_nxt = 1'b1;
                if (flush_cnt) begin
                    state_nxt      = ST_DONE;
                    best_valid_nxt = 1'b1;
                end
            end
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt   <= '0;
            cand_cnt  <= '0;
            s1_sum    <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_idx    <= '0;
            acc       <= '0;
            sad_valid <= 1'b0;
            sad_o     <= '0;
            sad_idx   <= '0;
            best_sad  <= '0;
            best_idx  <= '0;
        end else if (start_ok) begin
            row_cnt   <= '0;
            cand_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            acc       <= '0;
            sad_valid <= 1'b0;
            best_sad  <= '1;
            best_idx  <= '0;
        end else begin
            if (accept) begin
                row_cnt <= last_beat ? '0 : row_cnt + 1'b1;
                s1_sum  <= tree_sum;
                if (last_beat) begin
                    cand_cnt <= (cand_cnt == IDX_LAST) ? '0 : cand_cnt + 1'b1;
                end
            end
            s1_valid  <= accept;
            s1_last   <= last_beat;
            s1_idx    <= cand_cnt;
            sad_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    acc     <= '0;
                    sad_o   <= acc_sum;
                    sad_idx <= s1_idx;
                end else begin
                    acc <= acc_sum;
                end
            end
            // Strict compare: on a tie the earlier candidate index is kept.
            if (sad_valid && (sad_o < best_sad)) begin
                best_sad <= sad_o;
                best_idx <= sad_idx;
            end
        end
    end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker: table of full searches plus reset, busy-start
// and (when ME_EARLY_TERM_EN is defined) early-termination sequences.
module tb_sad_min_tracker;

    localparam int NUM_PE   = 16;
    localparam int AD_W     = 8;
    localparam int BLK_ROWS = 16;
    localparam int NUM_CAND = 64;
    localparam int SAD_W    = 16;
    localparam int IDX_W    = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   ad_valid = 1'b0;
    logic [NUM_PE*AD_W-1:0] ad_i = '0;
    logic                   busy, sad_valid, best_valid;
    logic [SAD_W-1:0]       sad_o, best_sad;
    logic [IDX_W-1:0]       sad_idx, best_idx;
`ifdef ME_EARLY_TERM_EN
    logic [SAD_W-1:0]       term_thresh = '0;
`endif

    sad_min_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ad_valid   (ad_valid),
        .ad_i       (ad_i),
`ifdef ME_EARLY_TERM_EN
        .term_thresh(term_thresh),
`endif
        .busy       (busy),
        .sad_valid  (sad_valid),
        .sad_o      (sad_o),
        .sad_idx    (sad_idx),
        .best_valid (best_valid),
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    base_val;
        int    zero_cand;
        int    zero_val;
        bit    stalls;
        bit    poke_start;
        int    exp_sad;
        int    exp_idx;
    } vec_t;

    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   mon_cand = 0;
    int   mon_val[NUM_CAND];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NUM_PE*AD_W-1:0] lanes_of(input int v);
        logic [NUM_PE*AD_W-1:0] r;
        for (int k = 0; k < NUM_PE; k++) r[k*AD_W +: AD_W] = AD_W'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Candidate SAD for uniform lanes of value v is v * NUM_PE * BLK_ROWS.
    always @(negedge clk) begin
        if (mon_en && sad_valid) begin
            if (mon_cand < NUM_CAND) begin
                check($sformatf("sad_idx[%0d]", mon_cand), sad_idx, mon_cand);
                check($sformatf("sad_o[%0d]", mon_cand), sad_o, mon_val[mon_cand] * NUM_PE * BLK_ROWS);
            end else begin
                check("sad_valid_extra", mon_cand, NUM_CAND - 1);
            end
            mon_cand++;
        end
    end

    task automatic run_search(input vec_t v);
        for (int c = 0; c < NUM_CAND; c++) mon_val[c] = (c == v.zero_cand) ? v.zero_val : v.base_val;
        ad_valid = 1'b1;
        ad_i     = lanes_of(200);
        tick();
        ad_valid = 1'b0;
        mon_cand = 0;
        mon_en   = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({v.name, ".busy_after_start"}, busy, 1);
        for (int c = 0; c < NUM_CAND; c++) begin
            for (int r = 0; r < BLK_ROWS; r++) begin
                if (v.stalls) begin
                    repeat ($urandom_range(0, 5)) begin
                        ad_valid = 1'b0;
                        ad_i     = lanes_of(99);
                        tick();
                    end
                end
                ad_valid = 1'b1;
                ad_i     = lanes_of(mon_val[c]);
                start    = v.poke_start && (c == 10) && (r == 3);
                tick();
            end
        end
        ad_valid = 1'b0;
        start    = 1'b0;
        ad_i     = '0;
        check({v.name, ".best_valid_t1"}, best_valid, 0);
        check({v.name, ".busy_t1"}, busy, 1);
        tick();
        check({v.name, ".best_valid_t2"}, best_valid, 0);
        tick();
        check({v.name, ".best_valid_t3"}, best_valid, 1);
        check({v.name, ".busy_t3"}, busy, 0);
        check({v.name, ".best_sad"}, best_sad, v.exp_sad);
        check({v.name, ".best_idx"}, best_idx, v.exp_idx);
        tick();
        check({v.name, ".best_valid_t4"}, best_valid, 0);
        check({v.name, ".best_sad_held"}, best_sad, v.exp_sad);
        check({v.name, ".best_idx_held"}, best_idx, v.exp_idx);
        check({v.name, ".busy_done"}, busy, 0);
        check({v.name, ".sad_count"}, mon_cand, NUM_CAND);
        mon_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"uniform",     1,   -1, 0, 1'b0, 1'b0, 256,   0};
        vecs[1] = '{"single_zero", 1,   37, 0, 1'b0, 1'b1, 0,     37};
        vecs[2] = '{"saturation",  255, -1, 0, 1'b0, 1'b0, 65280, 0};
        vecs[3] = '{"stalls",      1,   37, 0, 1'b1, 1'b0, 0,     37};
        vecs[4] = '{"last_cand",   3,   63, 2, 1'b0, 1'b0, 512,   63};

        #3;
        check("reset.busy", busy, 0);
        check("reset.sad_valid", sad_valid, 0);
        check("reset.best_valid", best_valid, 0);
        check("reset.best_sad", best_sad, 0);
        check("reset.best_idx", best_idx, 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
`ifdef ME_EARLY_TERM_EN
            if (vecs[i].exp_sad == 0) continue;
`endif
            run_search(vecs[i]);
        end

        // Reset in the middle of candidate 20 aborts the search.
        for (int c = 0; c < NUM_CAND; c++) mon_val[c] = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 20 * BLK_ROWS + 5; b++) begin
            ad_valid = 1'b1;
            ad_i     = lanes_of(1);
            tick();
        end
        #2 rst = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.sad_valid", sad_valid, 0);
        check("midrst.sad_o", sad_o, 0);
        check("midrst.sad_idx", sad_idx, 0);
        check("midrst.best_valid", best_valid, 0);
        check("midrst.best_sad", best_sad, 0);
        check("midrst.best_idx", best_idx, 0);
        ad_valid = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("midrst.no_best_valid", best_valid, 0);
            check("midrst.idle_busy", busy, 0);
        end
        run_search(vecs[0]);

`ifdef ME_EARLY_TERM_EN
        // Candidate 5 has SAD 8, below the threshold of 10.
        term_thresh = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            for (int r = 0; r < BLK_ROWS; r++) begin
                ad_valid = 1'b1;
                ad_i     = lanes_of(c == 5 ? 0 : 1);
                if (c == 5 && r == 0) ad_i[AD_W-1:0] = 8'd8;
                tick();
            end
        end
        ad_i = lanes_of(1);
        tick();
        check("early.best_valid_t2", best_valid, 0);
        tick();
        check("early.best_valid_t3", best_valid, 1);
        check("early.busy_t3", busy, 0);
        check("early.best_sad", best_sad, 8);
        check("early.best_idx", best_idx, 5);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("early.ignored_sad_valid", sad_valid, 0);
            check("early.ignored_best_valid", best_valid, 0);
        end
        check("early.best_sad_held", best_sad, 8);
        check("early.best_idx_held", best_idx, 5);
        ad_valid    = 1'b0;
        term_thresh = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
